// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - icache lookup/refill controller; optional ICACHE_EARLY_RESTART_EN
`ifndef ITAG_SIZE
`define ITAG_SIZE 20
`endif
`ifndef ISET_INDEX_SIZE
`define ISET_INDEX_SIZE 7
`endif
`ifndef IBLOCK_SIZE_BITS
`define IBLOCK_SIZE_BITS 256
`endif

module icache_refill_ctrl #(
  parameter int TAG_W    = `ITAG_SIZE,
  parameter int IDX_W    = `ISET_INDEX_SIZE,
  parameter int BLK_BITS = `IBLOCK_SIZE_BITS,
  parameter int ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic [ADDR_W-1:0]       cpu_addr,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_data,
  output logic                    en,
  output logic                    memWen,
  output logic [TAG_W+IDX_W-1:0]  blockAddr,
  output logic [BLK_BITS-1:0]     dataIn,
  input  logic                    hit,
  input  logic [BLK_BITS-1:0]     dataOut,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_data
);

  localparam int BA_W   = TAG_W + IDX_W;
  localparam int NBEATS = BLK_BITS / 32;
  localparam int OFF_W  = $clog2(BLK_BITS / 8);
  localparam int WORD_W = OFF_W - 2;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(NBEATS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, FILL} state_t;

  state_t              state;
  logic [WORD_W-1:0]   beat;
  logic [WORD_W-1:0]   req_off;
  logic [BA_W-1:0]     req_blk;
  logic [BLK_BITS-1:0] buffer;
  logic [BLK_BITS-1:0] fill_block;
  logic [31:0]         hit_word;
  logic                ready_q;
  logic [31:0]         data_q;
  logic                en_q;
  logic                memwen_q;
  logic [BA_W-1:0]     blk_q;
  logic                accept;
  logic [BA_W-1:0]     cpu_blk;
  logic [WORD_W-1:0]   cpu_off;
  logic                unused_addr_bits;
`ifdef ICACHE_EARLY_RESTART_EN
  logic                early_hit;
`else
  logic [31:0]         fill_word;
`endif

  assign cpu_blk          = cpu_addr[ADDR_W-1 -: BA_W];
  assign cpu_off          = cpu_addr[OFF_W-1:2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Block to be written: buffered beats with the final beat taken straight from the bus
  always_comb begin
    fill_block = buffer;
    fill_block[(NBEATS-1)*32 +: 32] = mem_data;
    hit_word = dataOut[32*int'(req_off) +: 32];
`ifndef ICACHE_EARLY_RESTART_EN
    fill_word = fill_block[32*int'(req_off) +: 32];
`endif
  end

  // Lookup is issued in the request cycle itself so a hit loop takes two cycles per word
  always_comb begin
    accept    = rst && (state == IDLE) && cpu_req;
    en        = en_q | accept;
    memWen    = memwen_q;
    blockAddr = accept ? cpu_blk : blk_q;
`ifdef ICACHE_EARLY_RESTART_EN
    early_hit = (state == REFILL) && mem_valid && (beat == req_off);
    cpu_ready = ready_q | early_hit;
    cpu_data  = early_hit ? mem_data : data_q;
`else
    cpu_ready = ready_q;
    cpu_data  = data_q;
`endif
  end

  // Main FSM: request latch, hit return, beat assembly and the single fill cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat     <= '0;
      req_off  <= '0;
      req_blk  <= '0;
      buffer   <= '0;
      ready_q  <= 1'b0;
      data_q   <= '0;
      en_q     <= 1'b0;
      memwen_q <= 1'b0;
      blk_q    <= '0;
      dataIn   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      ready_q  <= 1'b0;
      en_q     <= 1'b0;
      memwen_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_blk <= cpu_blk;
            req_off <= cpu_off;
            blk_q   <= cpu_blk;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            ready_q <= 1'b1;
            data_q  <= hit_word;
            state   <= IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= ADDR_W'({req_blk, {OFF_W{1'b0}}});
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_valid) begin
            buffer[32*int'(beat) +: 32] <= mem_data;
            if (beat == LAST_BEAT) begin
              mem_req  <= 1'b0;
              en_q     <= 1'b1;
              memwen_q <= 1'b1;
              blk_q    <= req_blk;
              dataIn   <= fill_block;
`ifndef ICACHE_EARLY_RESTART_EN
              ready_q  <= 1'b1;
              data_q   <= fill_word;
`endif
              state    <= FILL;
            end else begin
              beat <= beat + WORD_W'(1);
            end
          end
        end
        FILL: begin
          beat  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
  localparam int BA_W = 27;
`ifdef ICACHE_EARLY_RESTART_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic          cpu_ready;
  logic [31:0]   cpu_data;
  logic          en;
  logic          memWen;
  logic [BA_W-1:0] blockAddr;
  logic [255:0]  dataIn;
  logic          hit = 1'b0;
  logic [255:0]  dataOut = '0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_valid;
  logic [31:0]   mem_data;

  int checks = 0;
  int failures = 0;
  int fill_count = 0;
  int lookup_count = 0;

  logic [BA_W-1:0] tag_tbl [16];
  logic            v_tbl   [16] = '{default: 1'b0};
  logic [255:0]    blk_tbl [16];

  always #5 clk = ~clk;

  icache_refill_ctrl #(.TAG_W(20), .IDX_W(7), .BLK_BITS(256), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .en(en), .memWen(memWen),
    .blockAddr(blockAddr), .dataIn(dataIn), .hit(hit), .dataOut(dataOut),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data)
  );

  // Small direct-mapped SRAM model: registered read, hit answers the previous cycle's access
  always @(posedge clk) begin
    if (en && memWen) begin
      tag_tbl[blockAddr[3:0]] <= blockAddr;
      v_tbl[blockAddr[3:0]]   <= 1'b1;
      blk_tbl[blockAddr[3:0]] <= dataIn;
      fill_count <= fill_count + 1;
    end
    if (en && !memWen) lookup_count <= lookup_count + 1;
    hit     <= en && !memWen && v_tbl[blockAddr[3:0]] && (tag_tbl[blockAddr[3:0]] == blockAddr);
    dataOut <= blk_tbl[blockAddr[3:0]];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  function automatic logic [255:0] blk(input logic [31:0] base);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[32*k +: 32] = base + 32'(k);
    return b;
  endfunction

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0; mem_valid = 1'b0; mem_data = '0;
    repeat (2) @(posedge clk);
    mid;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_data", cpu_data, 0);
    chk("rst_en", en, 0);
    chk("rst_wen", memWen, 0);
    chk("rst_baddr", blockAddr, 0);
    chk("rst_din", dataIn, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_maddr", mem_addr, 0);
    next;
    rst = 1'b1;

    // cold miss on 0x4, request held high throughout
    cpu_req = 1'b1; cpu_addr = 32'h4;
    mid;
    chk("cm_acc_en", en, 1);
    chk("cm_acc_wen", memWen, 0);
    chk("cm_acc_baddr", blockAddr, 0);
    next; mid;
    chk("cm_lookup_en", en, 0);
    chk("cm_lookup_mreq", mem_req, 0);
    next;
    for (int k = 0; k < 8; k++) begin
      mem_valid = 1'b1; mem_data = 32'h1000_0000 + 32'(k);
      mid;
      chk("cm_mreq", mem_req, 1);
      chk("cm_maddr", mem_addr, 32'h0);
      chk("cm_no_lookup", en, 0);
      chk("cm_ready", cpu_ready, (ER && k == 1) ? 1 : 0);
      if (ER && k == 1) chk("cm_early_data", cpu_data, 32'h1000_0001);
      next;
    end
    mem_valid = 1'b0;
    mid;
    chk("cm_fill_en", en, 1);
    chk("cm_fill_wen", memWen, 1);
    chk("cm_fill_mreq", mem_req, 0);
    chk("cm_fill_din", dataIn, blk(32'h1000_0000));
    chk("cm_fill_ready", cpu_ready, ER ? 0 : 1);
`ifndef ICACHE_EARLY_RESTART_EN
    chk("cm_fill_data", cpu_data, 32'h1000_0001);
`endif
    next;
    cpu_req = 1'b0;
    mid;
    chk("cm_idle_en", en, 0);
    chk("cm_idle_wen", memWen, 0);
    chk("cm_idle_ready", cpu_ready, 0);
    chk("cm_fills", fill_count, 1);
    chk("cm_lookups", lookup_count, 1);

    // stray beats while idle
    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    mid;
    chk("stray_mreq", mem_req, 0);
    next; mid;
    chk("stray_ready", cpu_ready, 0);
    chk("stray_en", en, 0);
    next;
    mem_valid = 1'b0;

    // hit on 0x8 then back-to-back hit on 0x1C
    cpu_req = 1'b1; cpu_addr = 32'h8;
    mid;
    chk("hit_acc_en", en, 1);
    chk("hit_acc_wen", memWen, 0);
    chk("hit_acc_baddr", blockAddr, 0);
    next; mid;
    chk("hit_lookup_ready", cpu_ready, 0);
    chk("hit_lookup_en", en, 0);
    next;
    cpu_addr = 32'h1C;
    mid;
    chk("hit_ready", cpu_ready, 1);
    chk("hit_data", cpu_data, 32'h1000_0002);
    chk("hit_mreq", mem_req, 0);
    chk("b2b_acc_en", en, 1);
    next;
    cpu_req = 1'b0;
    mid;
    chk("b2b_gap_ready", cpu_ready, 0);
    next; mid;
    chk("b2b_ready", cpu_ready, 1);
    chk("b2b_data", cpu_data, 32'h1000_0007);
    chk("b2b_mreq", mem_req, 0);
    chk("b2b_lookups", lookup_count, 3);
    next;

    // stalled refill of 0x2C, request dropped after acceptance
    cpu_req = 1'b1; cpu_addr = 32'h2C;
    mid;
    chk("st_baddr", blockAddr, 1);
    next;
    cpu_req = 1'b0; cpu_addr = 32'hFFFF_FFF0;
    next;
    for (int i = 0; i < 16; i++) begin
      mem_valid = i[0];
      mem_data = i[0] ? 32'h2000_0000 + 32'(i / 2) : 32'hBAD0_0000 + 32'(i);
      mid;
      chk("st_mreq", mem_req, 1);
      chk("st_maddr", mem_addr, 32'h20);
      chk("st_ready", cpu_ready, (ER && i[0] && i / 2 == 3) ? 1 : 0);
      next;
    end
    mem_valid = 1'b0;
    mid;
    chk("st_fill_wen", memWen, 1);
    chk("st_fill_baddr", blockAddr, 1);
    chk("st_fill_din", dataIn, blk(32'h2000_0000));
    chk("st_fill_ready", cpu_ready, ER ? 0 : 1);
`ifndef ICACHE_EARLY_RESTART_EN
    chk("st_fill_data", cpu_data, 32'h2000_0003);
`endif
    next; mid;
    chk("st_after_wen", memWen, 0);
    chk("st_fills", fill_count, 2);
    next;

    // reset after beat 3 of a refill of 0x40
    cpu_req = 1'b1; cpu_addr = 32'h40;
    next;
    cpu_req = 1'b0;
    next;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_data = 32'h3000_0000 + 32'(k);
      next;
    end
    mem_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_mreq", mem_req, 0);
    chk("mr_en", en, 0);
    chk("mr_wen", memWen, 0);
    chk("mr_ready", cpu_ready, 0);
    chk("mr_maddr", mem_addr, 0);
    chk("mr_baddr", blockAddr, 0);
    chk("mr_din", dataIn, 0);
    chk("mr_data", cpu_data, 0);
    next; next;
    rst = 1'b1;
    mid;
    chk("mr_no_fill", fill_count, 2);

    // re-request of 0x40 misses again; offset 0 exercises early restart when enabled
    next;
    cpu_req = 1'b1; cpu_addr = 32'h40;
    next;
    cpu_req = 1'b0;
    next; mid;
    chk("rr_mreq", mem_req, 1);
    chk("rr_maddr", mem_addr, 32'h40);
    next;
    for (int k = 0; k < 8; k++) begin
      mem_valid = 1'b1; mem_data = 32'h4000_0000 + 32'(k);
      mid;
      chk("rr_ready", cpu_ready, (ER && k == 0) ? 1 : 0);
      if (ER && k == 0) chk("rr_early_data", cpu_data, 32'h4000_0000);
      next;
    end
    mem_valid = 1'b0;
    mid;
    chk("rr_fill_wen", memWen, 1);
    chk("rr_fill_din", dataIn, blk(32'h4000_0000));
    chk("rr_fill_ready", cpu_ready, ER ? 0 : 1);
`ifndef ICACHE_EARLY_RESTART_EN
    chk("rr_fill_data", cpu_data, 32'h4000_0000);
`endif
    next; mid;
    chk("rr_fills", fill_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
